// File: rtl/seq_or_monitor_if.sv
// seq_or_monitor_if: control, sampled-signal and result bundle for seq_or_monitor.
//   master : drives en, clr, start, a, b, stop; observes results.
//   slave  : the monitor; samples inputs, drives pass, fail, err_sticky,
//            pass_cnt, fail_cnt (channel i counters at [i*CW +: CW]).
interface seq_or_monitor_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  logic              en;
  logic              clr;
  logic [NCH-1:0]    start;
  logic [NCH-1:0]    a;
  logic [NCH-1:0]    b;
  logic [NCH-1:0]    stop;
  logic [NCH-1:0]    pass;
  logic [NCH-1:0]    fail;
  logic [NCH-1:0]    err_sticky;
  logic [NCH*CW-1:0] pass_cnt;
  logic [NCH*CW-1:0] fail_cnt;

  modport master (
    output en, clr, start, a, b, stop,
    input  pass, fail, err_sticky, pass_cnt, fail_cnt
  );

  modport slave (
    input  en, clr, start, a, b, stop,
    output pass, fail, err_sticky, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/seq_or_monitor.sv
// seq_or_monitor: per-channel checker for
//   $rose(start) |=> (##D1 a) or (b ##D2 stop)     (|-> when OVERLAP=1)
// Every attempt resolves to exactly one pass or fail; overlapping attempts
// live in an age-indexed shift structure, one slot per age.
// Ports:
//   clk   : sampling clock, posedge
//   rst_n : synchronous active-low reset
//   bus   : seq_or_monitor_if.slave (en, clr, start, a, b, stop in;
//           pass, fail, err_sticky, pass_cnt, fail_cnt out)

// One channel. Attempt age k means "k edges after its trigger edge".
// Age 0 is the trigger itself (combinational); ages 1..L are registered.
module seq_or_lane #(
  parameter int D1      = 1,
  parameter int D2      = 2,
  parameter int OVERLAP = 0,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          start,
  input  logic          a,
  input  logic          b,
  input  logic          stop,
  output logic          pass,
  output logic          fail,
  output logic          err_sticky,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt
);
  localparam int ORG   = 1 - OVERLAP;          // age of consequent origin t0
  localparam int AGE_A = ORG + D1;             // age where a is required
  localparam int AGE_B = ORG + D2;             // age where stop is required
  localparam int L     = ORG + ((D1 > D2) ? D1 : D2);
  localparam int DEP   = (L > 0) ? L : 1;
  localparam int NW    = $clog2(L + 2);        // holds 0..L+1 resolutions

  logic           start_q;
  logic           trig;
  // slot j holds the attempt that will be age j+1 at the coming edge
  logic [DEP-1:0] v_q, av_q, bv_q;
  logic [DEP-1:0] v_nx, av_nx, bv_nx;
  logic [L:0]     p_k, f_k;
  logic [NW-1:0]  n_pass, n_fail;

  assign trig = en & start & ~start_q;

  genvar k;
  generate
    for (k = 0; k <= L; k++) begin : g_age
      logic vi, ai, bi, a_hit, b_ok, b_hit, an, bn;
      if (k == 0) begin : g_src
        assign {vi, ai, bi} = {trig, 1'b1, 1'b1};
      end else begin : g_src
        assign {vi, ai, bi} = {v_q[k-1], av_q[k-1], bv_q[k-1]};
      end
      assign a_hit  = ai && (k == AGE_A) && a;
      assign b_ok   = bi && !((k == ORG) && !b);
      assign b_hit  = b_ok && (k == AGE_B) && stop;
      // a branch stays viable only until its check age; at the check age it
      // either matched or died
      assign an     = ai && (k < AGE_A);
      assign bn     = b_ok && (k < AGE_B);
      // any match passes (both matching is still one pass)
      assign p_k[k] = vi && (a_hit || b_hit);
      assign f_k[k] = vi && !p_k[k] && !an && !bn;
      if (k < L) begin : g_fwd
        assign v_nx[k]  = vi && !p_k[k] && !f_k[k];
        assign av_nx[k] = an;
        assign bv_nx[k] = bn;
      end
    end
    if (L == 0) begin : g_nostage
      assign {v_nx, av_nx, bv_nx} = '0;
    end
  endgenerate

  always_comb begin
    n_pass = '0;
    n_fail = '0;
    for (int i = 0; i <= L; i++) begin
      n_pass = n_pass + NW'(p_k[i]);
      n_fail = n_fail + NW'(f_k[i]);
    end
  end

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] c, input logic [NW-1:0] n);
    logic [CW:0] s;
    s = {1'b0, c} + (CW+1)'(n);
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      v_q        <= '0;
      av_q       <= '0;
      bv_q       <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      err_sticky <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      start_q <= start;
      v_q     <= v_nx;
      av_q    <= av_nx;
      bv_q    <= bv_nx;
      // pulses report even when clr wipes the counters on the same edge
      pass    <= |p_k;
      fail    <= |f_k;
      if (clr) begin
        err_sticky <= 1'b0;
        pass_cnt   <= '0;
        fail_cnt   <= '0;
      end else begin
        if (|f_k) err_sticky <= 1'b1;
        pass_cnt <= sat_add(pass_cnt, n_pass);
        fail_cnt <= sat_add(fail_cnt, n_fail);
      end
    end
  end
endmodule

module seq_or_monitor #(
  parameter int NCH     = 4,
  parameter int D1      = 1,
  parameter int D2      = 2,
  parameter int OVERLAP = 0,
  parameter int CW      = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_or_monitor_if.slave  bus
);
  logic [NCH-1:0]         p, f, e;
  logic [NCH-1:0][CW-1:0] pcnt, fcnt;

  genvar ch;
  generate
    for (ch = 0; ch < NCH; ch++) begin : g_ch
      seq_or_lane #(.D1(D1), .D2(D2), .OVERLAP(OVERLAP), .CW(CW)) u_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (bus.en),
        .clr        (bus.clr),
        .start      (bus.start[ch]),
        .a          (bus.a[ch]),
        .b          (bus.b[ch]),
        .stop       (bus.stop[ch]),
        .pass       (p[ch]),
        .fail       (f[ch]),
        .err_sticky (e[ch]),
        .pass_cnt   (pcnt[ch]),
        .fail_cnt   (fcnt[ch])
      );
    end
  endgenerate

  assign bus.pass       = p;
  assign bus.fail       = f;
  assign bus.err_sticky = e;
  assign bus.pass_cnt   = pcnt;
  assign bus.fail_cnt   = fcnt;
endmodule

// File: tb/tb_seq_or_monitor.sv
// Bench for seq_or_monitor: dut0 uses defaults (D1=1, D2=2, |=>), dut1 uses
// OVERLAP=1, D1=0. Expected pulses go into per-DUT queues tagged with the
// edge they belong to; a negedge monitor pops and compares every cycle.
module tb_seq_or_monitor;
  localparam int NCH = 4;
  localparam int CW  = 8;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] p;
    logic [NCH-1:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [NCH-1:0] ep0, ef0, ep1, ef1;

  seq_or_monitor_if #(.NCH(NCH), .CW(CW)) bus0 ();
  seq_or_monitor_if #(.NCH(NCH), .CW(CW)) bus1 ();

  seq_or_monitor #(.NCH(NCH), .D1(1), .D2(2), .OVERLAP(0), .CW(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  seq_or_monitor #(.NCH(NCH), .D1(0), .D2(2), .OVERLAP(1), .CW(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1);
  end

  // scoreboard: pulses seen after edge N must equal the entry tagged N
  always @(negedge clk) begin
    ep0 = '0; ef0 = '0; ep1 = '0; ef1 = '0;
    while (q0.size() > 0 && q0[0].cyc < cyc) begin
      n_assert++; n_fail++;
      $display("FAIL dut0_missed: entry for edge %0d never compared (now %0d)", q0[0].cyc, cyc);
      void'(q0.pop_front());
    end
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      n_assert++; n_fail++;
      $display("FAIL dut1_missed: entry for edge %0d never compared (now %0d)", q1[0].cyc, cyc);
      void'(q1.pop_front());
    end
    if (q0.size() > 0 && q0[0].cyc == cyc) begin
      ep0 = q0[0].p; ef0 = q0[0].f; void'(q0.pop_front());
    end
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      ep1 = q1[0].p; ef1 = q1[0].f; void'(q1.pop_front());
    end
    n_assert++;
    if (bus0.pass !== ep0 || bus0.fail !== ef0) begin
      n_fail++;
      $display("FAIL dut0_pulse edge %0d: pass=%b fail=%b, expected pass=%b fail=%b",
               cyc, bus0.pass, bus0.fail, ep0, ef0);
    end
    n_assert++;
    if (bus1.pass !== ep1 || bus1.fail !== ef1) begin
      n_fail++;
      $display("FAIL dut1_pulse edge %0d: pass=%b fail=%b, expected pass=%b fail=%b",
               cyc, bus1.pass, bus1.fail, ep1, ef1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push0(input int c, input logic [NCH-1:0] p, input logic [NCH-1:0] f);
    exp_t e;
    e.cyc = c; e.p = p; e.f = f;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic [NCH-1:0] p, input logic [NCH-1:0] f);
    exp_t e;
    e.cyc = c; e.p = p; e.f = f;
    q1.push_back(e);
  endtask

  task automatic do_clr();
    bus0.clr = 1'b1; bus1.clr = 1'b1;
    tick();
    bus0.clr = 1'b0; bus1.clr = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    bus0.start[1] = 1'b1;          // held through reset: rises on first live edge
    repeat (3) tick();
    n_assert++;
    if (bus0.pass_cnt !== '0 || bus0.fail_cnt !== '0 || bus0.err_sticky !== '0) begin
      n_fail++;
      $display("FAIL reset_dut0: pcnt=%h fcnt=%h err=%b, expected all 0",
               bus0.pass_cnt, bus0.fail_cnt, bus0.err_sticky);
    end
    n_assert++;
    if (bus1.pass_cnt !== '0 || bus1.fail_cnt !== '0 || bus1.err_sticky !== '0) begin
      n_fail++;
      $display("FAIL reset_dut1: pcnt=%h fcnt=%h err=%b, expected all 0",
               bus1.pass_cnt, bus1.fail_cnt, bus1.err_sticky);
    end
    rst_n = 1'b1;
    e = cyc + 1;
    push0(e + 2, 4'b0010, 4'b0000);
    tick(); bus0.start[1] = 1'b0;
    tick(); bus0.a[1] = 1'b1;
    tick(); bus0.a[1] = 1'b0;
    repeat (4) tick();
    n_assert++;
    if (bus0.pass_cnt[1*CW +: CW] !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_first_edge_rise: pass_cnt[1]=%0d, expected 1", bus0.pass_cnt[1*CW +: CW]);
    end
    do_clr();
  endtask

  task automatic test_branch_a();
    int e;
    e = cyc + 1;
    bus0.start[0] = 1'b1;
    push0(e + 2, 4'b0001, 4'b0000);
    tick(); bus0.start[0] = 1'b0; bus0.b[0] = 1'b0;
    tick(); bus0.a[0] = 1'b1;
    tick(); bus0.a[0] = 1'b0;
    repeat (4) tick();
    n_assert++;
    if (bus0.pass_cnt[0 +: CW] !== 8'd1 || bus0.fail_cnt[0 +: CW] !== 8'd0) begin
      n_fail++;
      $display("FAIL branch_a_cnt: pass=%0d fail=%0d, expected 1 and 0",
               bus0.pass_cnt[0 +: CW], bus0.fail_cnt[0 +: CW]);
    end
    do_clr();
  endtask

  task automatic test_branch_b();
    int e;
    e = cyc + 1;
    bus0.start[0] = 1'b1;
    push0(e + 3, 4'b0001, 4'b0000);
    tick(); bus0.start[0] = 1'b0; bus0.b[0] = 1'b1;
    tick(); bus0.b[0] = 1'b0; bus0.a[0] = 1'b0;
    tick(); bus0.stop[0] = 1'b1;
    tick(); bus0.stop[0] = 1'b0;
    repeat (4) tick();
    n_assert++;
    if (bus0.pass_cnt[0 +: CW] !== 8'd1 || bus0.fail_cnt[0 +: CW] !== 8'd0) begin
      n_fail++;
      $display("FAIL branch_b_cnt: pass=%0d fail=%0d, expected 1 and 0",
               bus0.pass_cnt[0 +: CW], bus0.fail_cnt[0 +: CW]);
    end
    do_clr();
  endtask

  task automatic test_fail();
    int e;
    // early: b low at t0, a low at t0+1
    e = cyc + 1;
    bus0.start[0] = 1'b1;
    push0(e + 2, 4'b0000, 4'b0001);
    tick(); bus0.start[0] = 1'b0; bus0.b[0] = 1'b0;
    tick(); bus0.a[0] = 1'b0;
    repeat (4) tick();
    n_assert++;
    if (bus0.err_sticky[0] !== 1'b1 || bus0.fail_cnt[0 +: CW] !== 8'd1) begin
      n_fail++;
      $display("FAIL early_fail: err=%b fail_cnt=%0d, expected 1 and 1",
               bus0.err_sticky[0], bus0.fail_cnt[0 +: CW]);
    end
    // late: b high, a low, stop low
    e = cyc + 1;
    bus0.start[0] = 1'b1;
    push0(e + 3, 4'b0000, 4'b0001);
    tick(); bus0.start[0] = 1'b0; bus0.b[0] = 1'b1;
    tick(); bus0.b[0] = 1'b0; bus0.a[0] = 1'b0;
    tick(); bus0.stop[0] = 1'b0;
    repeat (4) tick();
    n_assert++;
    if (bus0.fail_cnt[0 +: CW] !== 8'd2 || bus0.pass_cnt[0 +: CW] !== 8'd0) begin
      n_fail++;
      $display("FAIL late_fail: fail_cnt=%0d pass_cnt=%0d, expected 2 and 0",
               bus0.fail_cnt[0 +: CW], bus0.pass_cnt[0 +: CW]);
    end
    do_clr();
    n_assert++;
    if (bus0.err_sticky[0] !== 1'b0 || bus0.fail_cnt[0 +: CW] !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_idle: err=%b fail_cnt=%0d, expected 0 and 0",
               bus0.err_sticky[0], bus0.fail_cnt[0 +: CW]);
    end
  endtask

  task automatic test_overlap();
    int e;
    e = cyc + 1;
    bus0.start[1] = 1'b1;
    push0(e + 2, 4'b0010, 4'b0000);
    push0(e + 4, 4'b0000, 4'b0010);
    tick(); bus0.start[1] = 1'b0;
    tick(); bus0.start[1] = 1'b1; bus0.a[1] = 1'b1;
    tick(); bus0.start[1] = 1'b0; bus0.a[1] = 1'b0;
    repeat (5) tick();
    n_assert++;
    if (bus0.pass_cnt[1*CW +: CW] !== 8'd1 || bus0.fail_cnt[1*CW +: CW] !== 8'd1) begin
      n_fail++;
      $display("FAIL overlap_cnt: pass=%0d fail=%0d, expected 1 and 1",
               bus0.pass_cnt[1*CW +: CW], bus0.fail_cnt[1*CW +: CW]);
    end
    do_clr();
  endtask

  task automatic test_overlap_mode();
    int e;
    // |-> with D1=0: a on the trigger edge passes immediately
    e = cyc + 1;
    bus1.start[2] = 1'b1; bus1.a[2] = 1'b1;
    push1(e, 4'b0100, 4'b0000);
    tick(); bus1.start[2] = 1'b0; bus1.a[2] = 1'b0;
    tick();
    // a and b both low on the trigger edge: fails immediately
    e = cyc + 1;
    bus1.start[2] = 1'b1;
    push1(e, 4'b0000, 4'b0100);
    tick(); bus1.start[2] = 1'b0;
    repeat (3) tick();
    n_assert++;
    if (bus1.pass_cnt[2*CW +: CW] !== 8'd1 || bus1.fail_cnt[2*CW +: CW] !== 8'd1
        || bus1.err_sticky[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_mode: pass=%0d fail=%0d err=%b, expected 1 1 1",
               bus1.pass_cnt[2*CW +: CW], bus1.fail_cnt[2*CW +: CW], bus1.err_sticky[2]);
    end
    do_clr();
  endtask

  task automatic test_back_to_back();
    int e;
    // attempt 1 passes via b..stop at age 2, attempt 2 via a at age 0: same edge
    e = cyc + 1;
    bus1.start[3] = 1'b1; bus1.a[3] = 1'b0; bus1.b[3] = 1'b1;
    push1(e + 2, 4'b1000, 4'b0000);
    tick(); bus1.start[3] = 1'b0; bus1.b[3] = 1'b0;
    tick(); bus1.start[3] = 1'b1; bus1.a[3] = 1'b1; bus1.stop[3] = 1'b1;
    tick(); bus1.start[3] = 1'b0; bus1.a[3] = 1'b0; bus1.stop[3] = 1'b0;
    repeat (4) tick();
    n_assert++;
    if (bus1.pass_cnt[3*CW +: CW] !== 8'd2 || bus1.fail_cnt[3*CW +: CW] !== 8'd0) begin
      n_fail++;
      $display("FAIL back_to_back: pass=%0d fail=%0d, expected 2 and 0",
               bus1.pass_cnt[3*CW +: CW], bus1.fail_cnt[3*CW +: CW]);
    end
    do_clr();
  endtask

  task automatic test_saturate();
    int e;
    bus1.a[2] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      e = cyc + 1;
      bus1.start[2] = 1'b1;
      push1(e, 4'b0100, 4'b0000);
      tick(); bus1.start[2] = 1'b0;
      tick();
    end
    bus1.a[2] = 1'b0;
    repeat (3) tick();
    n_assert++;
    if (bus1.pass_cnt[2*CW +: CW] !== 8'd255 || bus1.fail_cnt[2*CW +: CW] !== 8'd0) begin
      n_fail++;
      $display("FAIL saturate: pass=%0d fail=%0d, expected 255 and 0",
               bus1.pass_cnt[2*CW +: CW], bus1.fail_cnt[2*CW +: CW]);
    end
    do_clr();
  endtask

  task automatic test_reset_pending();
    bus0.start[0] = 1'b1;
    tick(); bus0.start[0] = 1'b0; rst_n = 1'b0;
    tick(); bus0.a[0] = 1'b1; bus0.b[0] = 1'b1; bus0.stop[0] = 1'b1;
    tick(); rst_n = 1'b1;
    repeat (3) tick();
    bus0.a[0] = 1'b0; bus0.b[0] = 1'b0; bus0.stop[0] = 1'b0;
    repeat (3) tick();
    n_assert++;
    if (bus0.pass_cnt !== '0 || bus0.fail_cnt !== '0 || bus0.err_sticky !== '0
        || bus0.pass !== '0 || bus0.fail !== '0) begin
      n_fail++;
      $display("FAIL reset_pending: pcnt=%h fcnt=%h err=%b, expected all 0",
               bus0.pass_cnt, bus0.fail_cnt, bus0.err_sticky);
    end
  endtask

  task automatic test_en();
    int e;
    // en low on the rise: no attempt even though a would match
    bus0.en = 1'b0; bus0.start[0] = 1'b1;
    tick(); bus0.en = 1'b1; bus0.start[0] = 1'b0;
    tick(); bus0.a[0] = 1'b1;
    tick(); bus0.a[0] = 1'b0;
    repeat (3) tick();
    n_assert++;
    if (bus0.pass_cnt[0 +: CW] !== 8'd0 || bus0.fail_cnt[0 +: CW] !== 8'd0) begin
      n_fail++;
      $display("FAIL en_block: pass=%0d fail=%0d, expected 0 and 0",
               bus0.pass_cnt[0 +: CW], bus0.fail_cnt[0 +: CW]);
    end
    // en dropped after the trigger: attempt still runs to a pass
    e = cyc + 1;
    bus0.start[0] = 1'b1;
    push0(e + 2, 4'b0001, 4'b0000);
    tick(); bus0.en = 1'b0; bus0.start[0] = 1'b0;
    tick(); bus0.a[0] = 1'b1;
    tick(); bus0.a[0] = 1'b0; bus0.en = 1'b1;
    repeat (3) tick();
    n_assert++;
    if (bus0.pass_cnt[0 +: CW] !== 8'd1) begin
      n_fail++;
      $display("FAIL en_drop_midflight: pass=%0d, expected 1", bus0.pass_cnt[0 +: CW]);
    end
    do_clr();
  endtask

  task automatic test_clr();
    int e;
    e = cyc + 1;
    bus0.start[0] = 1'b1;
    push0(e + 2, 4'b0000, 4'b0001);
    tick(); bus0.start[0] = 1'b0; bus0.b[0] = 1'b0;
    tick(); bus0.a[0] = 1'b0; bus0.clr = 1'b1;
    tick(); bus0.clr = 1'b0;
    repeat (3) tick();
    n_assert++;
    if (bus0.fail_cnt[0 +: CW] !== 8'd0 || bus0.err_sticky[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_vs_fail: fail_cnt=%0d err=%b, expected 0 and 0",
               bus0.fail_cnt[0 +: CW], bus0.err_sticky[0]);
    end
  endtask

  initial begin
    bus0.en = 1'b1; bus0.clr = 1'b0;
    bus0.start = '0; bus0.a = '0; bus0.b = '0; bus0.stop = '0;
    bus1.en = 1'b1; bus1.clr = 1'b0;
    bus1.start = '0; bus1.a = '0; bus1.b = '0; bus1.stop = '0;
    test_reset();
    test_branch_a();
    test_branch_b();
    test_fail();
    test_overlap();
    test_overlap_mode();
    test_back_to_back();
    test_saturate();
    test_reset_pending();
    test_en();
    test_clr();
    repeat (2) tick();
    n_assert++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_or_monitor.md
# seq_or_monitor

Synthesizable, multi-channel hardware monitor that implements sequence-OR composition: `$rose(start) |=> (##D1 a) or (b ##D2 stop)` per channel. The implication mode (non-overlapped or overlapped) is a parameter. Each attempt resolves to exactly one pass or one fail, and overlapping attempts are tracked independently. The block sits beside the design under test in simulation and on FPGA builds where SVA is unavailable, and drives per-channel pass/fail pulses, sticky error flags and saturating counters.

## Interface
- NCH, 4, number of independent channels (1..16)
- D1, 1, cycles from consequent start to required `a` (0..7)
- D2, 2, cycles from `b` to required `stop` (0..7)
- OVERLAP, 0, 0 = non-overlapped (`|=>`, consequent starts one edge after trigger); 1 = overlapped (`|->`, same edge)
- CW, 8, counter width

- clk  in  1  sampling clock; all sampling on posedge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  trigger enable; low blocks new attempts, in-flight attempts continue
- clr  in  1  synchronous clear of counters and sticky flags
- start  in  NCH  antecedent signals
- a  in  NCH  branch-A signals
- b  in  NCH  branch-B first element
- stop  in  NCH  branch-B second element
- pass  out  NCH  one-cycle pulse: at least one attempt on channel passed
- fail  out  NCH  one-cycle pulse: at least one attempt on channel failed
- err_sticky  out  NCH  set on any fail; held until clr or reset
- pass_cnt  out  NCH*CW  per-channel saturating pass count, channel i at [i*CW +: CW]
- fail_cnt  out  NCH*CW  per-channel saturating fail count

## Operation
- Per channel, register start_q (start sampled at the previous edge). Trigger at edge T when start=1, start_q=0 and en=1.
- Consequent origin t0 = T + (OVERLAP ? 0 : 1).
- Branch A matches iff `a`=1 at edge t0+D1.
- Branch B matches iff `b`=1 at t0 and `stop`=1 at t0+D2.
- Per attempt, track A-viable and B-viable flags plus age since T. The window length is L = 1-OVERLAP+max(D1,D2). Implement as a per-channel age-indexed shift structure of depth L+1, so attempts can overlap without limit.
- B becomes non-viable at t0 if b=0, or at t0+D2 if stop=0. A becomes non-viable at t0+D1 if a=0.
- Resolution edge R:
  - R is the first edge at which either branch matches. The attempt passes and is retired, and its other branch is no longer observed.
  - Otherwise R is the edge at which the last viable branch dies, and the attempt fails.
- Exactly one resolution per attempt.
- If A matches and B completes on the same edge, this counts as one pass.
- The same channel can resolve several attempts on one edge. The pass/fail pulses are ORed; the counters add the number of attempts resolved (saturate at 2^CW-1).
- clr at the same edge as a resolution: clear wins for counters and sticky; the pass/fail pulses still fire.
- en drop mid-attempt has no effect on that attempt.

## Timing
- pass/fail are registered at edge R and high for exactly the cycle following R.
- Counters and err_sticky update at edge R.
- A start already high at the first edge after reset counts as a rise, because start_q resets to 0.
- Reset (rst_n=0 sampled at an edge):
  - clears start_q, all in-flight attempts, pass, fail, err_sticky and counters to 0.
  - Attempts pending at reset never report.
  - No triggers occur on the reset edge.
- D1=0 with OVERLAP=1: `a` is sampled on the trigger edge itself, so resolution latency is 0 edges after T.
- D2=0: b and stop must both be 1 at t0.
- Maximum latency T→R = 1-OVERLAP+max(D1,D2) edges.

## Test plan
Defaults (NCH=4, D1=1, D2=2, OVERLAP=0), start[0] rising at edge E:
- **Branch A pass:** a[0]=1 at E+2, b[0]=0 → pass[0] pulse after E+2; pass_cnt[0]=1; fail[0] never asserts.
- **Branch B pass:** a[0]=0 at E+2, b[0]=1 at E+1, stop[0]=1 at E+3 → pass[0] after E+3; fail_cnt[0]=0.
- **Early fail and late fail:**
  - b[0]=0 at E+1 and a[0]=0 at E+2 → fail[0] after E+2, err_sticky[0]=1.
  - Separately, b=1 at E+1, a=0 at E+2, stop=0 at E+3 → fail after E+3.
- **Overlapping attempts:** start[1] toggled 1,0,1 at E,E+1,E+2, with a[1]=1 only at E+2 → first attempt passes after E+2, second attempt (trigger E+2) fails by E+4 if b/a low; pass_cnt[1]=1, fail_cnt[1]=1.
- **OVERLAP=1, D1=0:** start[2] rises with a[2]=1 on the same edge → pass[2] pulse the next cycle. Then drive 300 such passes with CW=8 → pass_cnt[2] saturates at 255.
- **Reset and control:**
  - rst_n=0 at E+1 during a pending attempt → no pass/fail ever, all outputs 0.
  - en=0 at E → no attempt.
  - clr coincident with a fail → fail pulse fires, fail_cnt=0 and err_sticky=0 afterwards.
